// File: rtl/fence_inside_check.sv
// Point-in-fence test: loads an object point plus N_VERT angularly sorted vertices,
// then checks the sign of one edge cross product per cycle; boundary points are outside.
module fence_inside_check #(
  parameter int N_VERT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  output logic       in_ready,
  output logic       valid,
  output logic       is_inside
);

  // state | meaning
  // IDLE  | waiting for the object point (beat 0)
  // LOAD  | collecting vertices V0..V(N_VERT-1), gaps allowed
  // CALC  | one edge cross product per cycle
  // DONE  | one-cycle result strobe
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(N_VERT);
  localparam logic [CW-1:0] LAST = CW'(N_VERT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_beat;
  logic [CW-1:0] r_edge;
  logic [9:0]    r_ox, r_oy;
  logic [9:0]    r_vx [N_VERT];
  logic [9:0]    r_vy [N_VERT];
  logic          r_pos, r_neg, r_zero;
  logic          r_valid, r_inside;

  logic               w_beat;
  logic [CW-1:0]      w_j;
  logic signed [10:0] w_xi, w_yi, w_xj, w_yj, w_ox, w_oy;
  logic signed [10:0] w_dx_e, w_dy_e, w_dx_o, w_dy_o;
  logic signed [21:0] w_p1, w_p2;
  logic signed [22:0] w_c;
  logic               w_pos, w_neg, w_zero;

  assign in_ready  = (r_state == IDLE) || (r_state == LOAD);
  assign w_beat    = in_valid && in_ready;
  assign valid     = r_valid;
  assign is_inside = r_inside;

  assign w_j  = (r_edge == LAST) ? '0 : r_edge + CW'(1);
  assign w_xi = {1'b0, r_vx[r_edge]};
  assign w_yi = {1'b0, r_vy[r_edge]};
  assign w_xj = {1'b0, r_vx[w_j]};
  assign w_yj = {1'b0, r_vy[w_j]};
  assign w_ox = {1'b0, r_ox};
  assign w_oy = {1'b0, r_oy};

  // Differences span +/-1023 and products +/-1046529, so the 11/22/23-bit widths are exact.
  assign w_dx_e = w_xj - w_xi;
  assign w_dy_e = w_yj - w_yi;
  assign w_dx_o = w_ox - w_xi;
  assign w_dy_o = w_oy - w_yi;
  assign w_p1   = 22'(w_dx_e) * 22'(w_dy_o);
  assign w_p2   = 22'(w_dy_e) * 22'(w_dx_o);
  assign w_c    = 23'(w_p1) - 23'(w_p2);

  assign w_zero = (w_c == '0);
  assign w_neg  = w_c[22];
  assign w_pos  = !w_zero && !w_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_edge   <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
      r_inside <= 1'b0;
      for (int i = 0; i < N_VERT; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            r_ox    <= X;
            r_oy    <= Y;
            r_beat  <= '0;
            r_edge  <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            r_zero  <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_beat) begin
            r_vx[r_beat] <= X;
            r_vy[r_beat] <= Y;
            if (r_beat == LAST) begin
              r_edge  <= '0;
              r_state <= CALC;
            end else begin
              r_beat <= r_beat + CW'(1);
            end
          end
        end
        CALC: begin
          r_pos  <= r_pos || w_pos;
          r_neg  <= r_neg || w_neg;
          r_zero <= r_zero || w_zero;
          if (r_edge == LAST) begin
            // Fold in the last edge directly so the result registers on the DONE edge.
            r_valid  <= 1'b1;
            r_inside <= !(r_zero || w_zero) && !((r_pos || w_pos) && (r_neg || w_neg));
            r_state  <= DONE;
          end else begin
            r_edge <= r_edge + CW'(1);
          end
        end
        DONE: begin
          r_valid  <= 1'b0;
          r_inside <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fence_inside_check.sv
// Self-checking bench for fence_inside_check: directed fences plus randomized
// angularly sorted fences against an arithmetic point-in-fence model.
module tb_fence_inside_check;

  localparam int N = 6;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [9:0] X, Y;
  logic       in_ready, valid, is_inside;

  int n_total = 0;
  int n_bad   = 0;
  int n_valid = 0;
  int n_leak  = 0;

  int ox, oy;
  int vx [N];
  int vy [N];

  fence_inside_check #(.N_VERT(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .Y(Y),
    .in_ready(in_ready), .valid(valid), .is_inside(is_inside)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (reset && !valid && is_inside) n_leak++;
  end

  task automatic chk(input string tag, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Sign of each edge cross product; any zero or mixed signs means outside.
  function automatic int model_inside();
    bit p = 0, n = 0, z = 0;
    for (int i = 0; i < N; i++) begin
      int j = (i + 1) % N;
      int c = (vx[j] - vx[i]) * (oy - vy[i]) - (vy[j] - vy[i]) * (ox - vx[i]);
      if (c > 0) p = 1;
      else if (c < 0) n = 1;
      else z = 1;
    end
    return (!z && !(p && n)) ? 1 : 0;
  endfunction

  task automatic drive_idle(input bit noise);
    in_valid = noise ? 1'b1 : 1'b0;
    X = 10'($urandom);
    Y = 10'($urandom);
  endtask

  // Entered and left at a negedge; the next set may start at once.
  task automatic run_set(input string tag, input int gap_pct, input bit noise);
    int exp_in;
    int cnt;
    exp_in = model_inside();
    for (int b = 0; b <= N; b++) begin
      while ($urandom_range(99) < gap_pct) begin
        drive_idle(1'b0);
        @(negedge clk);
      end
      in_valid = 1'b1;
      X = 10'(b == 0 ? ox : vx[b-1]);
      Y = 10'(b == 0 ? oy : vy[b-1]);
      @(negedge clk);
    end
    cnt = 1;
    drive_idle(noise);
    while (!valid && cnt < N + 10) begin
      @(negedge clk);
      cnt++;
      drive_idle(noise);
    end
    chk({tag, "_latency"}, cnt, N + 1);
    chk({tag, "_inside"}, int'(is_inside), exp_in);
    @(negedge clk);
    drive_idle(1'b0);
    chk({tag, "_one_cycle"}, int'(valid), 0);
    chk({tag, "_ready_after"}, int'(in_ready), 1);
  endtask

  task automatic load_hex_fence(input bit reversed);
    int bx [N] = '{100, 200, 300, 200, 100, 0};
    int by [N] = '{0, 0, 100, 200, 200, 100};
    for (int i = 0; i < N; i++) begin
      vx[i] = reversed ? bx[N-1-i] : bx[i];
      vy[i] = reversed ? by[N-1-i] : by[i];
    end
  endtask

  task automatic random_fence();
    real ang [N];
    real t;
    int  cx, cy, r, x, y;
    bit  rev;
    cx = $urandom_range(300, 700);
    cy = $urandom_range(300, 700);
    for (int i = 0; i < N; i++) ang[i] = real'($urandom_range(3599)) * 3.14159265 / 1800.0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N - 1 - i; k++)
        if (ang[k] > ang[k+1]) begin
          t = ang[k]; ang[k] = ang[k+1]; ang[k+1] = t;
        end
    rev = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(50, 300);
      x = cx + $rtoi(r * $cos(ang[rev ? N-1-i : i]));
      y = cy + $rtoi(r * $sin(ang[rev ? N-1-i : i]));
      vx[i] = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
      vy[i] = (y < 0) ? 0 : (y > 1023) ? 1023 : y;
    end
    case ($urandom_range(3))
      0: begin
        x = $urandom_range(N - 1);
        ox = vx[x]; oy = vy[x];
      end
      1: begin ox = cx; oy = cy; end
      default: begin ox = $urandom_range(1023); oy = $urandom_range(1023); end
    endcase
  endtask

  initial begin
    int v0;
    reset = 1'b0;
    in_valid = 1'b0;
    X = '0;
    Y = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_inside", int'(is_inside), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);

    load_hex_fence(1'b0); ox = 150; oy = 100;
    run_set("t1_ccw", 0, 1'b0);
    load_hex_fence(1'b1);
    run_set("t2_cw", 0, 1'b0);
    load_hex_fence(1'b0); ox = 500; oy = 500;
    run_set("t3_far", 0, 1'b0);
    ox = 150; oy = 0;
    run_set("t3_edge", 0, 1'b0);
    ox = 150; oy = 100;
    run_set("t4_noise", 0, 1'b1);
    run_set("t4_next", 30, 1'b0);

    // Abort a partial set after beat 3 with an asynchronous reset.
    v0 = n_valid;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      X = 10'(b == 0 ? 700 : vx[b-1]);
      Y = 10'(b == 0 ? 700 : vy[b-1]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", int'(valid), 0);
    reset = 1'b1;
    repeat (N + 4) @(negedge clk);
    chk("t5_no_stale_valid", n_valid, v0);
    chk("t5_ready", int'(in_ready), 1);
    run_set("t5_full", 0, 1'b0);

    vx = '{0, 1023, 1023, 0, 0, 0};
    vy = '{0, 0, 1023, 1023, 512, 256};
    ox = 1023; oy = 1023;
    run_set("t6_corner", 0, 1'b0);
    ox = 511; oy = 511;
    run_set("t6_mid", 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      random_fence();
      run_set("rand", $urandom_range(40), 1'($urandom));
    end

    chk("inside_only_with_valid", n_leak, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fence_inside_check.md
FENCE_INSIDE_CHECK -- requirements
Module: fence_inside_check

Interface
REQ-001 SHALL have parameter N_VERT, default 6: fence vertex count; legal range 3..7.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: X/Y carry a point this cycle.
REQ-005 SHALL have port X, input, 10 bits: unsigned x coordinate.
REQ-006 SHALL have port Y, input, 10 bits: unsigned y coordinate.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a point this cycle.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle result strobe.
REQ-009 SHALL have port is_inside, output, 1 bit: result; meaningful only while valid=1.

Function
REQ-010 SHALL accept one point per cycle when in_valid=1 and in_ready=1 (a beat); in_valid while in_ready=0 is ignored.
REQ-011 SHALL take beat 0 as the object point (Ox,Oy) and beats 1..N_VERT as fence vertices V0..V(N_VERT-1).
REQ-012 SHALL require vertices already angularly sorted (sorted geofence output), either winding direction.
REQ-013 SHALL implement FSM states IDLE, LOAD, CALC, DONE.
REQ-014 SHALL use these transitions: IDLE->LOAD on first beat; LOAD->CALC on beat N_VERT; CALC->DONE after N_VERT evaluation cycles; DONE->IDLE after 1 cycle.
REQ-015 SHALL hold LOAD indefinitely across in_valid gaps; beat count is kept, with no timeout.
REQ-016 SHALL drive in_ready=1 in IDLE and LOAD, and in_ready=0 in CALC and DONE.
REQ-017 SHALL evaluate exactly one edge per CALC cycle, i=0..N_VERT-1, edge Vi->Vj with j=(i+1) mod N_VERT.
REQ-018 SHALL compute C_i=(Xj-Xi)*(Oy-Yi)-(Yj-Yi)*(Ox-Xi), with differences 11-bit signed, products 22-bit signed, and C_i 23-bit signed, never truncated.
REQ-019 SHALL track sticky flags pos_seen (C_i>0), neg_seen (C_i<0) and zero_seen (C_i==0), cleared on entry to LOAD.
REQ-020 SHALL output is_inside = !zero_seen && !(pos_seen && neg_seen).
REQ-021 SHALL treat a point on an edge or at a vertex as outside.
REQ-022 SHALL assert valid=1 only in DONE, for exactly 1 cycle, with is_inside registered.
REQ-023 SHALL drive is_inside=0 whenever valid=0.
REQ-024 SHALL have fixed latency: last vertex beat at cycle t gives valid at cycle t+N_VERT+1.
REQ-025 SHALL accept the first beat of the next set in IDLE on the cycle after DONE, with no bubble beyond DONE.
REQ-026 SHALL not depend on vertex or object register values from a previous set.

Reset
REQ-027 SHALL on reset=0 immediately force state=IDLE, beat counter=0, edge counter=0, flags=0, valid=0, is_inside=0 and in_ready=1 after release.
REQ-028 SHALL abort any partially loaded set or in-progress CALC on reset; no valid is produced for it.
REQ-029 SHALL clear coordinate registers to 0 on reset, although functional correctness does not rely on that.

Verification
REQ-030 SHALL pass test 1: O=(150,100), V=(100,0),(200,0),(300,100),(200,200),(100,200),(0,100) -> valid 7 cycles after last beat, is_inside=1.
REQ-031 SHALL pass test 2: same fence in reverse (clockwise) order, O=(150,100) -> is_inside=1.
REQ-032 SHALL pass test 3: fence from test 1, O=(500,500) -> is_inside=0; O=(150,0), on an edge -> is_inside=0.
REQ-033 SHALL pass test 4: fence from test 1, O=(150,100), in_valid pulsed high throughout CALC -> pulses ignored, is_inside=1, and next set loads correctly.
REQ-034 SHALL pass test 5: reset=0 after beat 3, then a full test-1 set -> no valid before the new set, is_inside=1.
REQ-035 SHALL pass test 6: extreme coordinates O=(1023,1023), V=(0,0),(1023,0),(1023,1023),(0,1023),(0,512),(0,256) -> no overflow, is_inside=0; then O=(511,511) -> is_inside=1.
